// File: rtl/bsg_link_seq_pkg.sv
// bsg_link_seq_pkg: shared state encoding and timer sizing for the downstream link reset sequencer
package bsg_link_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_IO_REL,
    S_WAIT_ACT,
    S_UP,
    S_FAIL
  } bsg_link_seq_state_e;
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/bsg_link_seq_timer.sv
// bsg_link_seq_timer: loadable down-counter that auto-reloads load_val_i when it expires, so phase chaining needs no load from done
module bsg_link_seq_timer #(
  parameter int width_p = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               done_o
);
  logic [width_p-1:0] r_count;
  always_ff @(posedge clk)
    if (rst) r_count <= '0;
    else r_count <= (load_i || r_count == '0) ? load_val_i : r_count - 1'b1;
  assign done_o = (r_count == '0) && !load_i;
endmodule

// File: rtl/bsg_link_ddr_downstream_reset_seq.sv
// bsg_link_ddr_downstream_reset_seq: orders io/core link resets, waits for channel activity, retries on timeout
module bsg_link_ddr_downstream_reset_seq
  import bsg_link_seq_pkg::*;
#(
  parameter int num_channels_p  = 2,
  parameter int reset_cycles_p  = 8,
  parameter int settle_cycles_p = 4,
  parameter int timeout_p       = 32,
  parameter int max_retries_p   = 3,
  localparam int rc_w_lp = $clog2(max_retries_p + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      down_i,
  input  logic [num_channels_p-1:0] ch_valid_i,
  output logic [num_channels_p-1:0] io_link_reset_o,
  output logic                      core_link_reset_o,
  output logic                      link_up_o,
  output logic                      busy_o,
  output logic                      error_o,
  output logic [rc_w_lp-1:0]        retry_cnt_o
);
  localparam int tw_lp = timer_width(reset_cycles_p, settle_cycles_p, timeout_p);
  localparam logic [tw_lp-1:0] rst_ld_lp = tw_lp'(reset_cycles_p - 1);
  localparam logic [tw_lp-1:0] set_ld_lp = tw_lp'(settle_cycles_p - 1);
  localparam logic [tw_lp-1:0] tmo_ld_lp = tw_lp'(timeout_p - 1);
  localparam logic [rc_w_lp-1:0] max_lp = rc_w_lp'(max_retries_p);
  bsg_link_seq_state_e r_state, w_state_nx;
  logic                      r_start;
  logic [num_channels_p-1:0] r_seen;
  logic [rc_w_lp-1:0]        w_retry_nx, w_retry_inc;
  logic [tw_lp-1:0]          w_load_val;
  logic                      w_load, w_done, w_complete;
  assign w_complete  = &(r_seen | ch_valid_i);
  assign w_retry_inc = (retry_cnt_o == max_lp) ? retry_cnt_o : retry_cnt_o + 1'b1;
  assign w_load_val  = (r_state == S_HOLD) ? set_ld_lp : (r_state == S_IO_REL) ? tmo_ld_lp : rst_ld_lp;
  bsg_link_seq_timer #(.width_p(tw_lp)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_load),
    .load_val_i(w_load_val),
    .done_o    (w_done)
  );
  always_comb begin
    w_state_nx = r_state;
    w_retry_nx = retry_cnt_o;
    w_load     = 1'b0;
    unique case (r_state)
      S_IDLE, S_FAIL: if (r_start) begin
        w_state_nx = S_HOLD;
        w_retry_nx = '0;
        w_load     = 1'b1;
      end
      S_HOLD:   if (w_done) w_state_nx = S_IO_REL;
      S_IO_REL: if (w_done) w_state_nx = S_WAIT_ACT;
      S_WAIT_ACT: if (w_complete) w_state_nx = S_UP;
        else if (w_done) begin
          w_retry_nx = w_retry_inc;
          w_state_nx = (w_retry_inc < max_lp) ? S_HOLD : S_FAIL;
        end
      S_UP: if (down_i) begin
        w_state_nx = S_HOLD;
        w_load     = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state           <= S_IDLE;
      r_start           <= 1'b0;
      r_seen            <= '0;
      io_link_reset_o   <= '1;
      core_link_reset_o <= 1'b1;
      link_up_o         <= 1'b0;
      busy_o            <= 1'b0;
      error_o           <= 1'b0;
      retry_cnt_o       <= '0;
    end else begin
      r_state           <= w_state_nx;
      r_start           <= start_i;
      r_seen            <= (r_state == S_WAIT_ACT) ? (r_seen | ch_valid_i) : '0;
      io_link_reset_o   <= {num_channels_p{!(w_state_nx inside {S_IO_REL, S_WAIT_ACT, S_UP})}};
      core_link_reset_o <= !(w_state_nx inside {S_WAIT_ACT, S_UP});
      link_up_o         <= w_state_nx == S_UP;
      busy_o            <= w_state_nx inside {S_HOLD, S_IO_REL, S_WAIT_ACT};
      error_o           <= w_state_nx == S_FAIL;
      retry_cnt_o       <= w_retry_nx;
    end
endmodule

// File: tb/tb_bsg_link_ddr_downstream_reset_seq.sv
// tb_bsg_link_ddr_downstream_reset_seq: directed scenarios plus random traffic against a phase/duration model
module tb_bsg_link_ddr_downstream_reset_seq;
  localparam int NC = 2, RST_C = 8, SET_C = 4, TMO = 32, MAXR = 3;
  localparam int RW = $clog2(MAXR + 1);
  localparam int VW = NC + 4 + RW;
  localparam int P_IDLE = 0, P_HOLD = 1, P_IOREL = 2, P_WAIT = 3, P_UP = 4, P_FAIL = 5;
  typedef struct packed {
    int ph;
    int age;
    int ret;
    logic [NC-1:0] seen;
    logic pst;
  } mst_t;
  logic clk = 0, rst, start_i, down_i;
  logic [NC-1:0] ch_valid_i, io_link_reset_o;
  logic core_link_reset_o, link_up_o, busy_o, error_o;
  logic [RW-1:0] retry_cnt_o;
  int errors = 0, checks = 0;
  logic chk_en = 0;
  mst_t m = '0;
  always #5 clk = ~clk;
  bsg_link_ddr_downstream_reset_seq #(
    .num_channels_p(NC), .reset_cycles_p(RST_C), .settle_cycles_p(SET_C),
    .timeout_p(TMO), .max_retries_p(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .down_i(down_i), .ch_valid_i(ch_valid_i),
    .io_link_reset_o(io_link_reset_o), .core_link_reset_o(core_link_reset_o),
    .link_up_o(link_up_o), .busy_o(busy_o), .error_o(error_o), .retry_cnt_o(retry_cnt_o)
  );
  // Phase model: each phase lasts a fixed number of edges counted up from entry.
  function automatic mst_t step(input mst_t s, input logic r, input logic st, input logic dn,
                                input logic [NC-1:0] v);
    mst_t n;
    logic [NC-1:0] sv;
    n = s;
    n.pst = st;
    n.age = s.age + 1;
    sv = s.seen | v;
    if (r) return mst_t'(0);
    case (s.ph)
      P_IDLE, P_FAIL: if (s.pst) begin n.ph = P_HOLD; n.ret = 0; end
      P_HOLD:  if (n.age == RST_C) n.ph = P_IOREL;
      P_IOREL: if (n.age == SET_C) n.ph = P_WAIT;
      P_WAIT: begin
        n.seen = sv;
        if (&sv) n.ph = P_UP;
        else if (n.age == TMO) begin
          n.ret = s.ret + 1;
          n.ph = (n.ret < MAXR) ? P_HOLD : P_FAIL;
        end
      end
      P_UP: if (dn) n.ph = P_HOLD;
      default: ;
    endcase
    if (n.ph != s.ph) begin n.age = 0; n.seen = '0; end
    return n;
  endfunction
  function automatic logic [VW-1:0] expv(input mst_t s);
    logic io_lo, co_lo, bsy;
    io_lo = s.ph inside {P_IOREL, P_WAIT, P_UP};
    co_lo = s.ph inside {P_WAIT, P_UP};
    bsy = s.ph inside {P_HOLD, P_IOREL, P_WAIT};
    return {{NC{!io_lo}}, !co_lo, s.ph == P_UP, bsy, s.ph == P_FAIL, RW'(s.ret)};
  endfunction
  wire logic [VW-1:0] dutv = {io_link_reset_o, core_link_reset_o, link_up_o, busy_o, error_o, retry_cnt_o};
  always @(posedge clk) m <= step(m, rst, start_i, down_i, ch_valid_i);
  always @(negedge clk)
    if (chk_en) begin
      checks++;
      if (dutv !== expv(m)) begin
        errors++;
        $display("FAIL model_cmp t=%0t: dut %b expected %b (io,core,up,busy,err,retry)", $time, dutv, expv(m));
      end
    end
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1; cyc(); rst = 0;
  endtask
  task automatic to_wait();
    start_i = 1; cyc(); start_i = 0;
    repeat (13) cyc();
  endtask
  initial begin
    rst = 1; start_i = 0; down_i = 0; ch_valid_i = 0;
    cyc(); cyc();
    chk("rst_io", io_link_reset_o, 2'b11);
    chk("rst_core", core_link_reset_o, 1);
    chk("rst_up", link_up_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", error_o, 0);
    chk("rst_retry", retry_cnt_o, 0);
    chk_en = 1;
    rst = 0;
    cyc();
    start_i = 1; cyc(); start_i = 0;
    chk("nom_busy_t0", busy_o, 0);
    repeat (8) cyc();
    chk("nom_io_t8", io_link_reset_o, 2'b11);
    chk("nom_busy_t8", busy_o, 1);
    cyc();
    chk("nom_io_t9", io_link_reset_o, 2'b00);
    chk("nom_core_t9", core_link_reset_o, 1);
    repeat (3) cyc();
    chk("nom_core_t12", core_link_reset_o, 1);
    ch_valid_i = 2'b11; cyc();
    chk("nom_core_t13", core_link_reset_o, 0);
    chk("nom_up_t13", link_up_o, 0);
    cyc(); ch_valid_i = 0;
    chk("nom_up_t14", link_up_o, 1);
    chk("nom_retry", retry_cnt_o, 0);
    chk("model_up_t14", m.ph, P_UP);
    do_reset(); to_wait();
    for (int c = 0; c <= 20; c++) begin
      ch_valid_i = (c == 3) ? 2'b01 : (c == 20) ? 2'b10 : 2'b00;
      if (c == 20) chk("stag_not_yet", link_up_o, 0);
      cyc();
    end
    ch_valid_i = 0;
    chk("stag_up", link_up_o, 1);
    chk("stag_retry", retry_cnt_o, 0);
    do_reset(); to_wait();
    repeat (31) cyc();
    chk("to_wait_core", core_link_reset_o, 0);
    cyc();
    chk("to_retry", retry_cnt_o, 1);
    chk("to_io", io_link_reset_o, 2'b11);
    chk("to_core", core_link_reset_o, 1);
    repeat (7) cyc();
    chk("to_hold_io", io_link_reset_o, 2'b11);
    cyc();
    chk("to_iorel_io", io_link_reset_o, 2'b00);
    repeat (3) cyc();
    ch_valid_i = 2'b11; cyc();
    chk("to_wait2_core", core_link_reset_o, 0);
    cyc(); ch_valid_i = 0;
    chk("to_up", link_up_o, 1);
    chk("to_up_retry", retry_cnt_o, 1);
    down_i = 1; cyc(); down_i = 0;
    chk("drop_up", link_up_o, 0);
    chk("drop_io", io_link_reset_o, 2'b11);
    chk("drop_core", core_link_reset_o, 1);
    chk("drop_busy", busy_o, 1);
    chk("drop_retry", retry_cnt_o, 1);
    do_reset(); to_wait();
    for (int c = 0; c < 32; c++) begin
      ch_valid_i = (c == 0) ? 2'b01 : (c == 31) ? 2'b10 : 2'b00;
      cyc();
    end
    ch_valid_i = 0;
    chk("bnd_up", link_up_o, 1);
    chk("bnd_retry", retry_cnt_o, 0);
    do_reset(); to_wait();
    repeat (119) cyc();
    chk("exh_err_before", error_o, 0);
    cyc();
    chk("exh_err", error_o, 1);
    chk("exh_retry", retry_cnt_o, 3);
    chk("exh_io", io_link_reset_o, 2'b11);
    chk("exh_core", core_link_reset_o, 1);
    chk("exh_busy", busy_o, 0);
    chk("model_fail", m.ph, P_FAIL);
    start_i = 1; cyc(); start_i = 0;
    chk("exh_err_held", error_o, 1);
    cyc();
    chk("exh_restart_err", error_o, 0);
    chk("exh_restart_retry", retry_cnt_o, 0);
    chk("exh_restart_busy", busy_o, 1);
    do_reset();
    start_i = 1; cyc(); start_i = 0;
    repeat (10) cyc();
    chk("iorel_io", io_link_reset_o, 2'b00);
    rst = 1; cyc(); rst = 0;
    chk("mid_rst_io", io_link_reset_o, 2'b11);
    chk("mid_rst_core", core_link_reset_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("model_idle", m.ph, P_IDLE);
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      start_i = ($urandom_range(0, 19) == 0);
      down_i = ($urandom_range(0, 49) == 0);
      for (int b = 0; b < NC; b++) ch_valid_i[b] = ($urandom_range(0, 23) == 0);
      cyc();
    end
    rst = 0; start_i = 0; down_i = 0; ch_valid_i = 0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bsg_link_ddr_downstream_reset_seq.md
Name: bsg_link_ddr_downstream_reset_seq

Overview:
Bring-up and recovery sequencer for a multi-channel DDR downstream link. It runs in the core clock domain.
- Drives the per-channel io-side link resets and the core-side link reset in the required order.
- Waits for every channel to show traffic, then declares link-up.
- Retries on timeout, up to a limit, before declaring failure.
It sits between system control (start/down requests) and the downstream link instances; it gates core consumption via link_up_o.

Parameters:
num_channels_p, 2, number of downstream channels sequenced
reset_cycles_p, 8, cycles all resets held high in HOLD (>=1)
settle_cycles_p, 4, cycles between io reset release and core reset release (>=1)
timeout_p, 32, cycles allowed in WAIT_ACT for all channels to show valid (>=1)
max_retries_p, 3, timeouts tolerated before entering FAIL (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start_i  input  1  request bring-up; level, sampled each cycle
down_i  input  1  link-down indication; forces re-sequence from UP
ch_valid_i  input  num_channels_p  per-channel io_valid, already synchronized to clk
io_link_reset_o  output  num_channels_p  per-channel io-side link reset
core_link_reset_o  output  1  core-side link reset
link_up_o  output  1  link operational; core may consume
busy_o  output  1  sequencing in progress (HOLD/IO_REL/WAIT_ACT)
error_o  output  1  sticky failure flag (FAIL state)
retry_cnt_o  output  clog2(max_retries_p+1)  timeouts since last start from IDLE/FAIL

Behaviour:
- All outputs are registered.
- On reset: state=IDLE, io_link_reset_o=all 1, core_link_reset_o=1, link_up_o=0, busy_o=0, error_o=0, retry_cnt_o=0, seen mask=0, timer=0.
- Reset asserted mid-operation returns to these values on the next edge, regardless of state.
- States are IDLE, HOLD, IO_REL, WAIT_ACT, UP, FAIL.
- IDLE:
  - All resets high.
  - start_i=1 -> HOLD; load timer=reset_cycles_p-1; clear retry_cnt.
- HOLD:
  - All resets high; busy_o=1.
  - Timer reaches 0 -> IO_REL; load settle_cycles_p-1.
  - io_link_reset_o drops to 0 on entry to IO_REL.
- IO_REL:
  - io resets low, core reset high.
  - Timer reaches 0 -> WAIT_ACT; load timeout_p-1; clear seen mask.
  - core_link_reset_o drops on entry to WAIT_ACT.
- WAIT_ACT:
  - seen mask |= ch_valid_i each cycle.
  - Once (seen | ch_valid_i) is all ones, go to UP next cycle; link_up_o=1 on that edge.
  - Timer reaches 0 with the mask incomplete is a timeout: retry_cnt++.
  - After a timeout: if the new retry_cnt < max_retries_p -> HOLD (resets reasserted, timer=reset_cycles_p-1); else -> FAIL.
  - Completion and timeout in the same cycle: completion wins.
- UP:
  - link_up_o=1, busy_o=0.
  - down_i=1 -> HOLD with link_up_o=0, retry_cnt preserved.
  - start_i is ignored in UP.
- FAIL:
  - error_o=1, all resets high, link_up_o=0.
  - start_i=1 -> HOLD; clear error_o and retry_cnt.
- Timing, with start_i sampled at edge t (defaults): io reset low at t+9, core reset low at t+13, earliest link_up_o at t+14.
- Timer width = clog2(max(reset_cycles_p, settle_cycles_p, timeout_p)); all compares are unsigned and saturate at 0.
- retry_cnt saturates at max_retries_p.
- Parameter values of 1 yield single-cycle states.
- ch_valid_i is ignored outside WAIT_ACT.

Decomposition:
- Shared package bsg_link_seq_pkg:
  - state enum bsg_link_seq_state_e.
  - timer width constant function.
- Sub-module bsg_link_seq_timer:
  - loadable down-counter; ports clk, rst, load_i, load_val_i, done_o.
  - done_o = (count==0) && !load_i.
  - It is instanced once and shared by HOLD, IO_REL and WAIT_ACT.

Test Plan:
- Nominal bring-up (defaults):
  - Stimulus: start_i pulse at t0; ch_valid_i=2'b11 from t0+13.
  - Required response: io_link_reset_o=2'b00 at t0+9, core_link_reset_o=0 at t0+13, link_up_o=1 at t0+14, retry_cnt_o=0.
- Staggered channels:
  - Stimulus: ch0 valid pulse at WAIT_ACT cycle 3, ch1 pulse at cycle 20.
  - Required response: link_up_o rises on cycle 21; no timeout.
- Single timeout then success:
  - Stimulus: no valid in the first WAIT_ACT window; both channels valid in the second window.
  - Required response: retry_cnt_o=1, resets reasserted for 8 cycles, then link_up_o=1.
- Exhaustion:
  - Stimulus: no valid ever.
  - Required response: after 3 timeouts error_o=1, retry_cnt_o=3, all resets high.
  - Follow-up: start_i then clears error_o and reaches HOLD.
- Link drop:
  - Stimulus: in UP, down_i=1 for 1 cycle.
  - Required response: next edge link_up_o=0, all resets 1, busy_o=1, retry_cnt_o unchanged.
- Boundary and reset:
  - Stimulus: completion and timer=0 in the same WAIT_ACT cycle.
  - Required response: UP.
  - Stimulus: rst asserted during IO_REL.
  - Required response: next edge all reset values, state IDLE.
